i_pmp_check: RTL and testbench

I_PMP_CHECK -- requirements
Module: i_pmp_check

---
 rtl/i_pmp_check_pkg.sv | 39 +++
 rtl/i_pmp_check_if.sv | 23 ++
 rtl/i_pmp_match.sv | 63 ++++++
 rtl/i_pmp_rule.sv | 30 +++
 rtl/i_pmp_check.sv | 179 +++++++++++++++++
 tb/tb_i_pmp_check.sv | 377 +++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/i_pmp_check_pkg.sv
// Shared PMP definitions: A-field encodings, pmpcfg bit positions and the
// packed pmpcfg layout used by the instruction-fetch PMP checker.
package i_pmp_check_pkg;

  typedef enum logic [1:0] {
    PMP_A_OFF   = 2'd0,
    PMP_A_TOR   = 2'd1,
    PMP_A_NA4   = 2'd2,
    PMP_A_NAPOT = 2'd3
  } pmp_a_e;

  localparam int unsigned PMPCFG_R_BIT = 0;
  localparam int unsigned PMPCFG_W_BIT = 1;
  localparam int unsigned PMPCFG_X_BIT = 2;
  localparam int unsigned PMPCFG_A_LSB = 3;
  localparam int unsigned PMPCFG_A_MSB = 4;
  localparam int unsigned PMPCFG_L_BIT = 7;

  typedef struct packed {
    logic       l;
    logic [1:0] rsvd;
    pmp_a_e     a;
    logic       x;
    logic       w;
    logic       r;
  } pmp_cfg_t;

  function automatic pmp_cfg_t unpack_cfg(input logic [7:0] b);
    pmp_cfg_t c;
    c.l    = b[PMPCFG_L_BIT];
    c.rsvd = 2'b00;
    c.a    = pmp_a_e'(b[PMPCFG_A_MSB:PMPCFG_A_LSB]);
    c.x    = b[PMPCFG_X_BIT];
    c.w    = b[PMPCFG_W_BIT];
    c.r    = b[PMPCFG_R_BIT];
    return c;
  endfunction

endpackage

// File: rtl/i_pmp_check_if.sv
// Fetch-side request/response channel of the PMP checker, plus privilege and flush.
interface i_pmp_check_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        m_mode_i;
  logic        flush_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_addr_o;
  logic        resp_fault_o;
  logic [3:0]  resp_entry_o;

  modport slave (
    input  req_valid_i, req_addr_i, m_mode_i, flush_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_addr_o, resp_fault_o, resp_entry_o
  );

  modport master (
    output req_valid_i, req_addr_i, m_mode_i, flush_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_addr_o, resp_fault_o, resp_entry_o
  );
endinterface

// File: rtl/i_pmp_match.sv
// Address decode of one PMP entry against an 8-byte fetch block:
// any = at least one byte covered, full = all eight bytes covered.
module i_pmp_match
  import i_pmp_check_pkg::*;
(
  input  pmp_cfg_t    cfg,
  input  logic [29:0] addr,
  input  logic [29:0] prev_addr,
  input  logic [28:0] blk_addr,
  output logic        any,
  output logic        full
);

  logic [32:0] blk_lo;
  logic [32:0] blk_hi;
  logic [32:0] tor_lo;
  logic [32:0] tor_hi;
  logic        tor_nonempty;
  logic        na4_hit;
  logic        napot_hit;
  logic [29:0] napot_mask;
  logic        cfg_unused;

  // 33-bit byte addresses so the block end and TOR top can reach 2^32
  assign blk_lo       = {1'b0, blk_addr, 3'b000};
  assign blk_hi       = blk_lo + 33'd8;
  assign tor_lo       = {1'b0, prev_addr, 2'b00};
  assign tor_hi       = {1'b0, addr, 2'b00};
  assign tor_nonempty = tor_lo < tor_hi;

  assign na4_hit = (addr[29:1] == blk_addr);

  // Trailing ones plus the following zero mark the don't-care word bits;
  // NAPOT regions are >= 8 bytes and aligned, so a block is all-in or all-out.
  assign napot_mask = addr ^ (addr + 30'd1);
  assign napot_hit  = ((({blk_addr, 1'b0}) ^ addr) & ~napot_mask) == 30'd0;

  assign cfg_unused = ^{cfg.l, cfg.rsvd, cfg.x, cfg.w, cfg.r};

  always_comb begin
    any  = 1'b0;
    full = 1'b0;
    case (cfg.a)
      PMP_A_TOR: begin
        any  = tor_nonempty && (blk_lo < tor_hi) && (blk_hi > tor_lo);
        full = tor_nonempty && (blk_lo >= tor_lo) && (blk_hi <= tor_hi);
      end
      PMP_A_NA4: begin
        any  = na4_hit;
        full = 1'b0;
      end
      PMP_A_NAPOT: begin
        any  = napot_hit;
        full = napot_hit;
      end
      default: begin
        any  = 1'b0;
        full = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/i_pmp_rule.sv
// Execute permission of one matching PMP entry, with and without Smepmp MML.
module i_pmp_rule
  import i_pmp_check_pkg::*;
(
  input  logic l,
  input  logic r,
  input  logic w,
  input  logic x,
  input  logic m_mode,
  input  logic mml,
  output logic exec
);

  always_comb begin
    exec = 1'b0;
    if (mml) begin
      // R=0,W=1 encodes shared regions: executable by both modes only when L=1
      if (!r && w) begin
        exec = l;
      end else if (l && r && w && x) begin
        exec = 1'b0;
      end else begin
        exec = x && (l == m_mode);
      end
    end else begin
      exec = (m_mode && !l) || x;
    end
  end

endmodule

// File: rtl/i_pmp_check.sv
// Two-stage instruction-fetch PMP checker: S1 captures per-entry match and
// permission vectors, S2 holds the priority-selected fault/entry result.
module i_pmp_check
  import i_pmp_check_pkg::*;
#(
  parameter int PMP_ENTRIES   = 8,
  parameter int ENABLE_SMEPMP = 1
) (
  input  logic                     cpu_clock_i,
  input  logic                     cpu_reset_i,
  i_pmp_check_if.slave             bus,
  input  logic [8*PMP_ENTRIES-1:0]  pmpcfg_i,
  input  logic [30*PMP_ENTRIES-1:0] pmpaddr_i,
  input  logic                     mml_i,
  input  logic                     mmwp_i
);

  localparam int N = PMP_ENTRIES;

  logic        mml_eff;
  logic        mmwp_eff;
  pmp_cfg_t    cfg       [N];
  logic [29:0] paddr     [N];
  logic [29:0] prev_addr [N];
  logic [N-1:0] any_next;
  logic [N-1:0] full_next;
  logic [N-1:0] exec_next;
  logic [28:0] blk_next;
  logic        addr_unused;

  logic         s1_valid_reg;
  logic [N-1:0] s1_any_reg;
  logic [N-1:0] s1_full_reg;
  logic [N-1:0] s1_exec_reg;
  logic [28:0]  s1_blk_reg;
  logic         s1_m_mode_reg;
  logic         s1_mml_reg;
  logic         s1_mmwp_reg;

  logic         s2_valid_reg;
  logic [28:0]  s2_blk_reg;
  logic         s2_fault_reg;
  logic [3:0]   s2_entry_reg;

  logic         s2_advance;
  logic         s1_load;
  logic         sel_hit;
  logic [3:0]   sel_idx;
  logic         sel_full;
  logic         sel_exec;
  logic         fault_next;

  generate
    if (ENABLE_SMEPMP != 0) begin : g_smepmp
      assign mml_eff  = mml_i;
      assign mmwp_eff = mmwp_i;
    end else begin : g_no_smepmp
      logic smepmp_unused;
      assign mml_eff       = 1'b0;
      assign mmwp_eff      = 1'b0;
      assign smepmp_unused = mml_i ^ mmwp_i;
    end
  endgenerate

  assign blk_next    = bus.req_addr_i[31:3];
  assign addr_unused = ^bus.req_addr_i[2:0];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_entry
      assign cfg[gi]   = unpack_cfg(pmpcfg_i[8*gi +: 8]);
      assign paddr[gi] = pmpaddr_i[30*gi +: 30];

      // TOR lower bound of entry 0 is address 0
      if (gi == 0) begin : g_first
        assign prev_addr[gi] = 30'd0;
      end else begin : g_rest
        assign prev_addr[gi] = paddr[gi-1];
      end

      i_pmp_match u_match (
        .cfg       (cfg[gi]),
        .addr      (paddr[gi]),
        .prev_addr (prev_addr[gi]),
        .blk_addr  (blk_next),
        .any       (any_next[gi]),
        .full      (full_next[gi])
      );

      i_pmp_rule u_rule (
        .l      (cfg[gi].l),
        .r      (cfg[gi].r),
        .w      (cfg[gi].w),
        .x      (cfg[gi].x),
        .m_mode (bus.m_mode_i),
        .mml    (mml_eff),
        .exec   (exec_next[gi])
      );
    end
  endgenerate

  assign s2_advance      = bus.resp_ready_i || !s2_valid_reg;
  assign s1_load         = !s1_valid_reg || s2_advance;
  assign bus.req_ready_o = !bus.flush_i && s1_load;

  always_comb begin
    sel_hit  = 1'b0;
    sel_idx  = 4'd0;
    sel_full = 1'b0;
    sel_exec = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (s1_any_reg[i]) begin
        sel_hit  = 1'b1;
        sel_idx  = 4'(i);
        sel_full = s1_full_reg[i];
        sel_exec = s1_exec_reg[i];
      end
    end
  end

  always_comb begin
    fault_next = 1'b1;
    if (sel_hit) begin
      fault_next = !sel_full || !sel_exec;
    end else if (s1_mml_reg) begin
      fault_next = 1'b1;
    end else if (s1_m_mode_reg) begin
      fault_next = s1_mmwp_reg;
    end else begin
      fault_next = 1'b1;
    end
  end

  always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
    if (cpu_reset_i) begin
      s1_valid_reg  <= 1'b0;
      s1_any_reg    <= '0;
      s1_full_reg   <= '0;
      s1_exec_reg   <= '0;
      s1_blk_reg    <= '0;
      s1_m_mode_reg <= 1'b0;
      s1_mml_reg    <= 1'b0;
      s1_mmwp_reg   <= 1'b0;
      s2_valid_reg  <= 1'b0;
      s2_blk_reg    <= '0;
      s2_fault_reg  <= 1'b0;
      s2_entry_reg  <= 4'd0;
    end else if (bus.flush_i) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      if (s2_advance) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          s2_blk_reg   <= s1_blk_reg;
          s2_fault_reg <= fault_next;
          s2_entry_reg <= sel_idx;
        end
      end
      if (s1_load) begin
        s1_valid_reg <= bus.req_valid_i;
        if (bus.req_valid_i) begin
          s1_any_reg    <= any_next;
          s1_full_reg   <= full_next;
          s1_exec_reg   <= exec_next;
          s1_blk_reg    <= blk_next;
          s1_m_mode_reg <= bus.m_mode_i;
          s1_mml_reg    <= mml_eff;
          s1_mmwp_reg   <= mmwp_eff;
        end
      end
    end
  end

  assign bus.resp_valid_o = s2_valid_reg;
  assign bus.resp_addr_o  = {s2_blk_reg, 3'b000};
  assign bus.resp_fault_o = s2_fault_reg;
  assign bus.resp_entry_o = s2_entry_reg;

endmodule

// File: tb/tb_i_pmp_check.sv
// Bench for i_pmp_check: byte-level reference model with a response queue,
// directed scenarios with literal expectations, then randomized traffic.
module tb_i_pmp_check;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i_pmp_check_if bus ();

  logic [8*N-1:0]  pmpcfg;
  logic [30*N-1:0] pmpaddr;
  logic            mml;
  logic            mmwp;
  logic [7:0]      cfg_b  [N];
  logic [29:0]     addr_w [N];

  always_comb begin
    pmpcfg  = '0;
    pmpaddr = '0;
    for (int i = 0; i < N; i++) begin
      pmpcfg[8*i +: 8]   = cfg_b[i];
      pmpaddr[30*i +: 30] = addr_w[i];
    end
  end

  i_pmp_check #(.PMP_ENTRIES(N), .ENABLE_SMEPMP(1)) dut (
    .cpu_clock_i (clk),
    .cpu_reset_i (rst),
    .bus         (bus),
    .pmpcfg_i    (pmpcfg),
    .pmpaddr_i   (pmpaddr),
    .mml_i       (mml),
    .mmwp_i      (mmwp)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void region(input int i, output longint lo, output longint hi);
    longint pa;
    longint size;
    int     k;
    pa = longint'({34'd0, addr_w[i]});
    lo = 0;
    hi = 0;
    case (cfg_b[i][4:3])
      2'd1: begin
        lo = (i == 0) ? 0 : longint'({34'd0, addr_w[i-1]}) * 4;
        hi = pa * 4;
      end
      2'd2: begin
        lo = pa * 4;
        hi = lo + 4;
      end
      2'd3: begin
        k = 0;
        while (k < 30 && addr_w[i][k]) k++;
        size = longint'(8) << k;
        lo   = (pa * 4) & ~(size - 1);
        hi   = lo + size;
      end
      default: ;
    endcase
  endfunction

  // Smepmp execute tables indexed by {L,R,W,X}
  function automatic logic allowed(input logic [7:0] c, input logic m, input logic ml);
    logic [15:0] m_tab;
    logic [15:0] u_tab;
    logic [3:0]  idx;
    m_tab = 16'h2E00;
    u_tab = 16'h0CA2;
    idx   = {c[7], c[0], c[1], c[2]};
    if (ml) return m ? m_tab[idx] : u_tab[idx];
    return m ? (!c[7] || c[2]) : c[2];
  endfunction

  function automatic void model(input logic [31:0] a, input logic m, input logic ml,
                                input logic mw, output logic f, output logic [3:0] e);
    longint base;
    longint lo;
    longint hi;
    int     cnt;
    bit     found;
    base  = longint'({32'd0, a & 32'hFFFF_FFF8});
    found = 0;
    f     = 1'b0;
    e     = 4'd0;
    for (int i = 0; i < N; i++) begin
      if (!found) begin
        region(i, lo, hi);
        cnt = 0;
        for (int b = 0; b < 8; b++)
          if (base + b >= lo && base + b < hi) cnt++;
        if (cnt > 0) begin
          found = 1;
          e     = 4'(i);
          f     = (cnt < 8) || !allowed(cfg_b[i], m, ml);
        end
      end
    end
    if (!found) f = ml ? 1'b1 : (m ? mw : 1'b1);
  endfunction

  typedef struct {
    int unsigned ready_at;
    logic [31:0] addr;
    logic        fault;
    logic [3:0]  entry;
  } exp_t;

  exp_t q[$];

  // Compare process: pipeline of depth two, result due two cycles after accept
  always @(negedge clk) begin
    logic exp_valid;
    logic exp_ready;
    exp_t item;
    if (rst) begin
      q.delete();
    end else begin
      exp_valid = (q.size() > 0) && (q[0].ready_at <= cyc);
      exp_ready = !bus.flush_i && (q.size() < 2 || bus.resp_ready_i);
      chk("mon_resp_valid", bus.resp_valid_o, exp_valid);
      chk("mon_req_ready", bus.req_ready_o, exp_ready);
      if (exp_valid && bus.resp_valid_o) begin
        chk("mon_resp_addr", bus.resp_addr_o, q[0].addr);
        chk("mon_resp_fault", bus.resp_fault_o, q[0].fault);
        chk("mon_resp_entry", bus.resp_entry_o, q[0].entry);
      end
      if (bus.flush_i) begin
        q.delete();
      end else begin
        if (exp_valid && bus.resp_ready_i) void'(q.pop_front());
        if (bus.req_valid_i && exp_ready) begin
          item.ready_at = cyc + 2;
          item.addr     = bus.req_addr_i & 32'hFFFF_FFF8;
          model(bus.req_addr_i, bus.m_mode_i, mml, mmwp, item.fault, item.entry);
          q.push_back(item);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < N; i++) begin
      cfg_b[i]  = 8'h00;
      addr_w[i] = 30'd0;
    end
  endtask

  task automatic flush_pulse();
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
  endtask

  task automatic one_req(input string name, input logic [31:0] a, input logic m,
                         input logic exp_f, input logic [3:0] exp_e);
    int         lat;
    logic       mf;
    logic [3:0] me;
    lat = 0;
    model(a, m, mml, mmwp, mf, me);
    chk({name, "_model_fault"}, mf, exp_f);
    chk({name, "_model_entry"}, me, exp_e);
    bus.req_valid_i  = 1'b1;
    bus.req_addr_i   = a;
    bus.m_mode_i     = m;
    bus.resp_ready_i = 1'b1;
    @(negedge clk);
    chk({name, "_req_ready"}, bus.req_ready_o, 1'b1);
    step();
    bus.req_valid_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.resp_valid_o) begin
        lat = k;
        break;
      end
      step();
    end
    chk({name, "_latency"}, lat, 2);
    chk({name, "_fault"}, bus.resp_fault_o, exp_f);
    chk({name, "_entry"}, bus.resp_entry_o, exp_e);
    chk({name, "_addr"}, bus.resp_addr_o, a & 32'hFFFF_FFF8);
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [29:0] base;
    int          k;

    rst              = 1'b1;
    bus.req_valid_i  = 1'b0;
    bus.req_addr_i   = 32'd0;
    bus.m_mode_i     = 1'b0;
    bus.flush_i      = 1'b0;
    bus.resp_ready_i = 1'b1;
    mml              = 1'b0;
    mmwp             = 1'b0;
    clear_cfg();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_resp_valid", bus.resp_valid_o, 1'b0);
    chk("reset_resp_fault", bus.resp_fault_o, 1'b0);
    chk("reset_resp_entry", bus.resp_entry_o, 4'd0);
    chk("reset_resp_addr", bus.resp_addr_o, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", bus.req_ready_o, 1'b1);
    step();

    // NAPOT 64 KiB at 0x8000_0000, RWX, U-mode fetch
    cfg_b[0]  = 8'h1F;
    addr_w[0] = 30'h2000_1FFF;
    flush_pulse();
    one_req("napot_u", 32'h8000_0100, 1'b0, 1'b0, 4'd0);

    // TOR [0x1000,0x1004) only covers half of the block
    clear_cfg();
    addr_w[0] = 30'h400;
    cfg_b[1]  = 8'h0C;
    addr_w[1] = 30'h401;
    flush_pulse();
    one_req("tor_partial", 32'h1000, 1'b0, 1'b1, 4'd1);
    addr_w[1] = 30'h402;
    flush_pulse();
    one_req("tor_full", 32'h1004, 1'b0, 1'b0, 4'd1);

    // No match: MML, legacy, MMWP
    clear_cfg();
    mml = 1'b1;
    flush_pulse();
    one_req("nomatch_mml_m", 32'h2000, 1'b1, 1'b1, 4'd0);
    one_req("nomatch_mml_u", 32'h2000, 1'b0, 1'b1, 4'd0);
    mml = 1'b0;
    flush_pulse();
    one_req("nomatch_m", 32'h2000, 1'b1, 1'b0, 4'd0);
    mmwp = 1'b1;
    flush_pulse();
    one_req("nomatch_mmwp", 32'h2000, 1'b1, 1'b1, 4'd0);
    mmwp = 1'b0;

    // MML machine-only executable region
    mml       = 1'b1;
    cfg_b[0]  = 8'h9C;
    addr_w[0] = 30'h3FFF_FFFF;
    flush_pulse();
    one_req("mml_lx_m", 32'h2000, 1'b1, 1'b0, 4'd0);
    one_req("mml_lx_u", 32'h2000, 1'b0, 1'b1, 4'd0);

    // Back-pressure: three offered, two held, in-order release
    clear_cfg();
    mml = 1'b0;
    flush_pulse();
    bus.resp_ready_i = 1'b0;
    bus.req_valid_i  = 1'b1;
    bus.m_mode_i     = 1'b1;
    bus.req_addr_i   = 32'h0000_0100;
    @(negedge clk); chk("bp_ready0", bus.req_ready_o, 1'b1); step();
    bus.req_addr_i = 32'h0000_0208;
    @(negedge clk); chk("bp_ready1", bus.req_ready_o, 1'b1); step();
    bus.req_addr_i = 32'h0000_0310;
    for (int c = 2; c < 5; c++) begin
      @(negedge clk);
      chk("bp_ready_stall", bus.req_ready_o, 1'b0);
      chk("bp_hold_valid", bus.resp_valid_o, 1'b1);
      chk("bp_hold_addr", bus.resp_addr_o, 32'h0000_0100);
      chk("bp_hold_fault", bus.resp_fault_o, 1'b0);
      step();
    end
    bus.resp_ready_i = 1'b1;
    @(negedge clk); chk("bp_rel0", bus.resp_addr_o, 32'h0000_0100); step();
    bus.req_valid_i = 1'b0;
    @(negedge clk); chk("bp_rel1", bus.resp_addr_o, 32'h0000_0208); step();
    @(negedge clk); chk("bp_rel2", bus.resp_addr_o, 32'h0000_0310); step();
    @(negedge clk); chk("bp_drained", bus.resp_valid_o, 1'b0); step();

    // Flush with both stages full and a request offered
    bus.resp_ready_i = 1'b0;
    bus.req_valid_i  = 1'b1;
    bus.req_addr_i   = 32'h0000_0400;
    step();
    bus.req_addr_i = 32'h0000_0408;
    step();
    bus.flush_i    = 1'b1;
    bus.req_addr_i = 32'h0000_0410;
    @(negedge clk);
    chk("flush_ready", bus.req_ready_o, 1'b0);
    step();
    bus.flush_i     = 1'b0;
    bus.req_valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("flush_no_resp", bus.resp_valid_o, 1'b0);
      step();
    end

    // Asynchronous reset discards in-flight checks immediately
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 32'h0000_0500;
    step();
    bus.req_addr_i = 32'h0000_0508;
    step();
    bus.req_valid_i = 1'b0;
    rst = 1'b1;
    #2;
    chk("async_reset_valid", bus.resp_valid_o, 1'b0);
    chk("async_reset_addr", bus.resp_addr_o, 32'd0);
    step();
    rst = 1'b0;
    bus.resp_ready_i = 1'b1;
    @(negedge clk);
    chk("after_async_reset_ready", bus.req_ready_o, 1'b1);
    step();

    // Randomized traffic over random configurations
    for (int round = 0; round < 24; round++) begin
      bus.req_valid_i = 1'b0;
      for (int i = 0; i < N; i++) begin
        cfg_b[i] = {$urandom_range(0, 1) == 1, 2'b00, 2'($urandom_range(0, 3)),
                    3'($urandom_range(0, 7))};
        if (cfg_b[i][4:3] == 2'd3) begin
          k         = $urandom_range(0, 7);
          base      = 30'($urandom_range(0, 30'h3FF));
          addr_w[i] = (base & ~((30'd1 << (k + 1)) - 30'd1)) | ((30'd1 << k) - 30'd1);
        end else begin
          addr_w[i] = 30'($urandom_range(0, 30'h3FF));
        end
      end
      mml  = 1'($urandom_range(0, 1));
      mmwp = 1'($urandom_range(0, 1));
      flush_pulse();
      for (int c = 0; c < 150; c++) begin
        bus.req_valid_i  = ($urandom_range(0, 3) != 0);
        bus.req_addr_i   = $urandom_range(0, 32'h10FF);
        bus.m_mode_i     = 1'($urandom_range(0, 1));
        bus.resp_ready_i = ($urandom_range(0, 2) != 0);
        bus.flush_i      = ($urandom_range(0, 49) == 0);
        step();
      end
      bus.flush_i      = 1'b0;
      bus.req_valid_i  = 1'b0;
      bus.resp_ready_i = 1'b1;
      repeat (4) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
